// File: rtl/mips_dmem.sv
`default_nettype none
// ============================================================================
// Module   : mips_dmem
// Brief    : Data-side memory for the single-cycle Mips core: word RAM plus
//            memory-mapped OUT/IN/CYC/STAT registers, combinational reads.
// Revision : 1.0 - initial release
// ============================================================================
module mips_dmem #(
    parameter int AW   = 6,
    parameter int OUTW = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            memwrite,
    input  logic [31:0]     aluout,
    input  logic [31:0]     writedata,
    output logic [31:0]     readdata,
    output logic [OUTW-1:0] io_out,
    input  logic [OUTW-1:0] io_in,
    output logic            err
);

    localparam logic [1:0] SEL_OUT  = 2'd0;
    localparam logic [1:0] SEL_IN   = 2'd1;
    localparam logic [1:0] SEL_CYC  = 2'd2;
    localparam logic [1:0] SEL_STAT = 2'd3;

    logic [31:0]     mem [0:(2**AW)-1];
    logic [OUTW-1:0] out_reg;
    logic [OUTW-1:0] in_meta;
    logic [OUTW-1:0] in_sync;
    logic [31:0]     cyc;
    logic            flag;

    logic            is_io;
    logic [1:0]      sel;
    logic [AW-1:0]   idx;
    logic            aligned;
    logic            wr_ok;
    logic            io_wr;
    logic            unused_bits;

    assign is_io   = aluout[31];
    assign sel     = aluout[3:2];
    assign idx     = aluout[AW+1:2];
    assign aligned = (aluout[1:0] == 2'b00);
    assign wr_ok   = memwrite && aligned;
    assign io_wr   = wr_ok && is_io;

    // High address bits are don't-care so the RAM aliases across its region.
    assign unused_bits = ^aluout[30:AW+2];

    // RAM has no reset; gating on reset drops a store that overlaps reset.
    always_ff @(posedge clk) begin
        if (reset && wr_ok && !is_io) begin
            mem[idx] <= writedata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_reg <= '0;
            in_meta <= '0;
            in_sync <= '0;
            cyc     <= '0;
            flag    <= 1'b0;
        end else begin
            in_meta <= io_in;
            in_sync <= in_meta;

            if (io_wr && sel == SEL_CYC) begin
                cyc <= '0;
            end else begin
                cyc <= cyc + 32'd1;
            end

            if (io_wr && sel == SEL_OUT) begin
                out_reg <= writedata[OUTW-1:0];
            end

            // A misaligned store takes priority over a clear request.
            if (memwrite && !aligned) begin
                flag <= 1'b1;
            end else if (io_wr && sel == SEL_STAT && writedata[0]) begin
                flag <= 1'b0;
            end
        end
    end

    always_comb begin
        readdata = '0;
        if (is_io) begin
            case (sel)
                SEL_OUT:  readdata[OUTW-1:0] = out_reg;
                SEL_IN:   readdata[OUTW-1:0] = in_sync;
                SEL_CYC:  readdata           = cyc;
                SEL_STAT: readdata[0]        = flag;
                default:  readdata           = '0;
            endcase
        end else begin
            readdata = mem[idx];
        end
    end

    assign io_out = out_reg;
    assign err    = flag;

endmodule
`default_nettype wire

// File: doc/mips_dmem.md
Name: mips_dmem

Overview:
- Data-memory responder for the single-cycle Mips core. It sits on the core's data-side bus: memwrite, aluout as the address, writedata and readdata.
- It provides a word-addressed RAM plus a small memory-mapped I/O window: an output register, a synchronised input port, a cycle counter and a sticky status register.
- Reads are combinational, because the core has no stall. All writes and all state updates happen on the rising clock edge.

Parameters:
AW, 6, log2 of RAM depth in 32-bit words (default 64 words = 256 bytes)
OUTW, 8, width of io_out register and io_in port (1..32)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
memwrite  input  1  store strobe from core, sampled at rising clk
aluout  input  32  byte address from core
writedata  input  32  store data from core
readdata  output  32  load data to core, combinational from aluout
io_out  output  OUTW  memory-mapped output register
io_in  input  OUTW  asynchronous external input
err  output  1  copy of sticky misaligned-store flag (status bit0)

Behaviour:
- Address decode uses aluout[31]:
  - 0: RAM region. Word index = aluout[AW+1:2]. Bits [30:AW+2] are ignored, so addresses alias.
  - 1: I/O region. Register select = aluout[3:2]. Bits [30:4] are ignored.
- I/O map:
  - sel 0 OUT: R/W, OUTW bits. Reads zero-extended.
  - sel 1 IN: read-only, returns the 2-flop-synchronised io_in, zero-extended. Writes ignored.
  - sel 2 CYC: 32-bit free-running counter. A write of any data clears it.
  - sel 3 STAT: bit0 = misaligned-store flag, other bits read 0. Writing bit0=1 clears the flag; writing bit0=0 has no effect.
- Reads: readdata is a pure function of aluout and current state, with zero cycle latency. aluout[1:0] is ignored on reads, so a misaligned read returns the aligned word and raises no flag.
- Writes: only when memwrite=1 at the rising edge. A store with aluout[1:0] != 0 is misaligned:
  - no RAM or register is modified;
  - the flag is set on that edge.
- RAM write: mem[index] <= writedata. A read of the same address in the same cycle returns the old value; the new value is visible from the next cycle.
- CYC:
  - increments by 1 every cycle; wraps 0xFFFFFFFF -> 0;
  - a write to CYC in a cycle loads 0 (write wins over increment). The next cycle reads 0, the cycle after reads 1.
- STAT: if a misaligned store and a clear-write coincide, set wins. This cannot occur from a single port, but the priority is fixed for completeness.
- IN synchroniser: two flops. A change on io_in becomes readable after two rising edges.
- Reset (reset=0, asynchronous):
  - io_out=0, CYC=0, flag=0, err=0, synchroniser flops=0;
  - readdata follows decode of the reset state;
  - RAM contents are NOT reset and are undefined until written.
- Reset asserted mid-store: the store is discarded. Deassertion is synchronised by the system; the block itself resumes on the first edge with reset=1.
- err = STAT bit0, registered, with no extra latency.
- Widths: OUT write takes writedata[OUTW-1:0], upper bits dropped. All reads are zero-extended to 32 bits.

Test Plan:
- Reset, then write RAM 0x00000010 <= 0xDEADBEEF. Read 0x10 -> 0xDEADBEEF next cycle; in the write cycle it returns the prior value. Read 0x110 (AW=6 alias) -> 0xDEADBEEF.
- Misaligned store:
  - memwrite to 0x00000012 with 0x12345678 -> RAM word 4 unchanged, err=1 after the edge;
  - write 0x1 to 0x8000000C -> err=0;
  - write 0x0 to 0x8000000C -> err stays unchanged.
- Store 0x1A5 to 0x80000000 -> io_out=0xA5 (OUTW=8); read 0x80000000 -> 0x000000A5. Store to 0x80000004 -> no change anywhere.
- Release reset at edge 0; CYC read equals the number of edges since release. Write to 0x80000008 at edge k -> read 0 after edge k, 1 after edge k+1. Force CYC=0xFFFFFFFF via a long run or a backdoor -> next read 0.
- io_in 0x00 -> 0x3C between edges -> read 0x80000004 returns 0 after one edge and 0x3C after two. Assert reset mid-run -> io_out, CYC, err and synchroniser all 0 immediately, without waiting for clk.
